image_read: RTL

//  Source end of the HSYNC/VGA_data pixel stream: holds a BMP pixel array (BGR, bottom-up

---
 rtl/image_read.sv | 132 +++++++++++++
 1 files changed

// File: rtl/image_read.sv
// image_read: source end of the HSYNC/VGA_data pixel stream.
// Holds a BMP pixel array (BGR triplets, bottom-up rows, no header). On a start request
// it streams the frame top row first as 8-bit gray pixels, one per HSYNC-high cycle.
// Ports:
//   HCLK      clock, all logic on the rising edge
//   HRESET    asynchronous active-high reset; aborts any frame in progress
//   start     frame request, sampled only while idle
//   VSYNC     high during the start-delay phase of a frame
//   HSYNC     pixel-valid qualifier for VGA_data
//   VGA_data  gray pixel, forced to 0 while HSYNC is low
//   busy      high in every state except idle
//   read_done one-cycle pulse after the last pixel of a frame
module image_read #(
  parameter int unsigned WIDTH       = 768,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned FILESIZE    = 3 * WIDTH * DEPTH,
  parameter string       INFILE      = "dog.hex",
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned HBLANK      = 160
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       start,
  output logic       VSYNC,
  output logic       HSYNC,
  output logic [7:0] VGA_data,
  output logic       busy,
  output logic       read_done
);

  localparam int unsigned AW = (FILESIZE > 1) ? $clog2(FILESIZE) : 1;

  typedef enum logic [2:0] {StIdle, StVsync, StHblank, StData, StDone} state_e;

  logic [7:0] mem [FILESIZE];

  state_e      state_q;
  logic [31:0] row_q, col_q, dly_q;
  logic        vsync_q, hsync_q, done_q;
  logic [7:0]  data_q;

  // Pixel fetched for the cycle after the current edge: column 0 when leaving HBLANK,
  // otherwise the next column of the current row.
  logic [31:0]   rd_col, base;
  logic [AW-1:0] addr_b, addr_g, addr_r;
  logic [9:0]    sum;
  logic [7:0]    pix_next;

  always_comb begin
    rd_col = 32'd0;
    if (state_q == StData && col_q != WIDTH - 1) rd_col = col_q + 32'd1;
    // BMP rows are stored bottom-up, so output row r lives at stored row DEPTH-1-r.
    base   = 3 * WIDTH * (DEPTH - 1 - row_q) + 3 * rd_col;
    addr_b = AW'(base);
    addr_g = AW'(base + 32'd1);
    addr_r = AW'(base + 32'd2);
    sum    = {2'b00, mem[addr_r]} + {1'b0, mem[addr_g], 1'b0} + {2'b00, mem[addr_b]};
    pix_next = sum[9:2];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= StIdle;
      row_q   <= 32'd0;
      col_q   <= 32'd0;
      dly_q   <= 32'd0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StVsync;
            dly_q   <= 32'd0;
            vsync_q <= 1'b1;
          end
        end
        StVsync: begin
          if (dly_q == START_DELAY - 1) begin
            state_q <= StHblank;
            dly_q   <= 32'd0;
            vsync_q <= 1'b0;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        StHblank: begin
          if (dly_q == HBLANK - 1) begin
            state_q <= StData;
            col_q   <= 32'd0;
            hsync_q <= 1'b1;
            data_q  <= pix_next;
          end else begin
            dly_q <= dly_q + 32'd1;
          end
        end
        StData: begin
          if (col_q == WIDTH - 1) begin
            hsync_q <= 1'b0;
            data_q  <= 8'd0;
            if (row_q == DEPTH - 1) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StHblank;
              row_q   <= row_q + 32'd1;
              dly_q   <= 32'd0;
            end
          end else begin
            col_q  <= col_q + 32'd1;
            data_q <= pix_next;
          end
        end
        StDone: begin
          state_q <= StIdle;
          row_q   <= 32'd0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign VSYNC     = vsync_q;
  assign HSYNC     = hsync_q;
  assign VGA_data  = data_q;
  assign read_done = done_q;
  assign busy      = (state_q != StIdle);

endmodule
